xbar_rd: RTL and testbench
==========================

Name: xbar_rd

Overview:
- Single-master, two-slave AXI4-Lite read-channel crossbar.
- Sits between the LSU read port and the read targets:
  - slave 0: main memory / SRAM bridge.
  - slave 1: the CLINT mtime block.
- Decodes the AR address, forwards the request to exactly one slave and routes that slave's R beat back.
- Unmapped addresses get a locally generated DECERR; one transaction is outstanding at a time.

Parameters:
- MEM_BASE, 32'h8000_0000, slave 0 match value.
- MEM_MASK, 32'hF800_0000, slave 0 address mask (128 MiB window).
- CLINT_BASE, 32'h0200_0000, slave 1 match value.
- CLINT_MASK, 32'hFFFF_0000, slave 1 address mask (64 KiB window).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- arvalid_i  in  1  master read-address valid
- arready_o  out  1  master read-address ready
- araddr_i  in  32  master read address
- rvalid_o  out  1  master read-data valid
- rready_i  in  1  master read-data ready
- rdata_o  out  32  master read data
- rresp_o  out  2  master read response (00 OKAY, 10 SLVERR, 11 DECERR)
- s0_arvalid_o  out  1  slave 0 address valid
- s0_arready_i  in  1  slave 0 address ready
- s0_araddr_o  out  32  slave 0 address
- s0_rvalid_i  in  1  slave 0 data valid
- s0_rready_o  out  1  slave 0 data ready
- s0_rdata_i  in  32  slave 0 data
- s0_rresp_i  in  2  slave 0 response
- s1_arvalid_o  out  1  slave 1 address valid
- s1_arready_i  in  1  slave 1 address ready
- s1_araddr_o  out  32  slave 1 address
- s1_rvalid_i  in  1  slave 1 data valid
- s1_rready_o  out  1  slave 1 data ready
- s1_rdata_i  in  32  slave 1 data (slave 1 has no resp; treated as OKAY)

Behaviour:
- Decode, evaluated on araddr_i:
  - hit0 = (araddr_i & MEM_MASK) == MEM_BASE.
  - hit1 = (araddr_i & CLINT_MASK) == CLINT_BASE.
  - If both hit, slave 0 wins.
  - Neither hit means unmapped.
- Registers:
  - addr_q[31:0] and sel_q[1:0], where 0 = slave 0, 1 = slave 1, 2 = error.
  - A 2-bit state register.
- IDLE:
  - arready_o=1 and all slave valids/readies are 0.
  - On arvalid_i, latch addr_q and sel_q.
  - Next state is AR, or ERR if unmapped.
- AR:
  - arready_o=0.
  - s{sel}_arvalid_o=1 and s{sel}_araddr_o=addr_q. The other slave's arvalid is 0.
  - On s{sel}_arready_i, go to R.
  - arvalid is never dropped before the handshake.
- R:
  - Combinational pass-through from the selected slave:
    - rvalid_o = s{sel}_rvalid_i.
    - rdata_o = s{sel}_rdata_i.
    - rresp_o = s0_rresp_i, or 2'b00 for slave 1.
    - s{sel}_rready_o = rready_i.
  - On rvalid_o && rready_i, go to IDLE.
- ERR:
  - rvalid_o=1, rdata_o=32'h0, rresp_o=2'b11.
  - No slave is touched.
  - On rready_i, go to IDLE.
- Outside R and ERR: rvalid_o=0, rdata_o=0, rresp_o=0, and all slave rready=0.
- The s*_araddr_o ports always drive addr_q, so only arvalid qualifies them.
- Latency:
  - Master AR acceptance to slave arvalid: 1 cycle.
  - Response is zero-cycle pass-through.
  - Back-to-back transactions: the next arready_o rises the cycle after the R handshake.
  - Minimum CLINT read is 3 cycles from AR accept to rvalid_o: accept, forward, slave response.
- Unselected slave R inputs are ignored. A stray s*_rvalid_i from an unselected slave is not forwarded and not acknowledged.
- Reset:
  - While reset is high, state goes to IDLE and arready_o=0. All other outputs are 0. addr_q and sel_q are cleared.
  - Reset mid-transaction abandons it; slave-side valid/ready drop the cycle after reset asserts.

Test Plan:
- Read araddr_i=32'h0200_0000, s1 ready immediately, rdata 32'h0000_1234 -> s1_arvalid_o high 1 cycle with addr 32'h0200_0000, then rvalid_o with rdata_o=32'h0000_1234, rresp_o=00, and s0 untouched.
- Read 32'h0200_000C then 32'h8000_0010 back-to-back, s0 returns 32'hDEAD_BEEF with rresp 00 -> each routed to the correct slave, in order, and arready_o=0 between AR accept and the R handshake.
- Read unmapped 32'h1000_0000 -> no slave arvalid; the cycle after accept rvalid_o=1, rdata_o=0, rresp_o=11, and it is held until rready_i.
- Slave 0 holds s0_arready_i low 5 cycles, then rvalid_i with rresp 10 while rready_i low 3 cycles -> s0_arvalid_o and addr stable all 5 cycles; rvalid_o, rdata_o and rresp_o=10 stable until rready_i; return to IDLE.
- Reset asserted in R state with slave 1 selected -> next cycle all outputs 0; after release arready_o=1 and a new read to 32'h8000_0000 completes normally.
- Stray s0_rvalid_i=1 while in IDLE and while slave 1 is selected -> rvalid_o stays 0 and s0_rready_o stays 0.

Source files
------------

// File: rtl/xbar_rd.sv
// AXI4-Lite read-channel crossbar: one master, memory (slave 0) and CLINT (slave 1).
// One transaction in flight; unmapped reads are answered locally with DECERR.
module xbar_rd #(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_MASK   = 32'hF800_0000,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [31:0] araddr_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        s0_arvalid_o,
  input  logic        s0_arready_i,
  output logic [31:0] s0_araddr_o,
  input  logic        s0_rvalid_i,
  output logic        s0_rready_o,
  input  logic [31:0] s0_rdata_i,
  input  logic [1:0]  s0_rresp_i,
  output logic        s1_arvalid_o,
  input  logic        s1_arready_i,
  output logic [31:0] s1_araddr_o,
  input  logic        s1_rvalid_i,
  output logic        s1_rready_o,
  input  logic [31:0] s1_rdata_i
);

  typedef enum logic [1:0] {IDLE, AR, R, ERR} state_t;

  localparam logic [1:0] SEL_MEM   = 2'd0;
  localparam logic [1:0] SEL_CLINT = 2'd1;
  localparam logic [1:0] SEL_ERR   = 2'd2;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  sel_q, sel_d;
  logic        hit0, hit1;

  assign hit0 = (araddr_i & MEM_MASK) == MEM_BASE;
  assign hit1 = (araddr_i & CLINT_MASK) == CLINT_BASE;

  // Slave addresses always show the latched address; only arvalid qualifies them.
  assign s0_araddr_o = addr_q;
  assign s1_araddr_o = addr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      sel_q   <= SEL_MEM;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    arready_o    = 1'b0;
    rvalid_o     = 1'b0;
    rdata_o      = 32'h0;
    rresp_o      = 2'b00;
    s0_arvalid_o = 1'b0;
    s0_rready_o  = 1'b0;
    s1_arvalid_o = 1'b0;
    s1_rready_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is masked while reset is held so nothing is accepted then.
        arready_o = ~reset;
        if (arvalid_i) begin
          addr_d = araddr_i;
          if (hit0) begin
            sel_d   = SEL_MEM;
            state_d = AR;
          end else if (hit1) begin
            sel_d   = SEL_CLINT;
            state_d = AR;
          end else begin
            sel_d   = SEL_ERR;
            state_d = ERR;
          end
        end
      end
      AR: begin
        if (sel_q == SEL_MEM) begin
          s0_arvalid_o = 1'b1;
          if (s0_arready_i) state_d = R;
        end else if (sel_q == SEL_CLINT) begin
          s1_arvalid_o = 1'b1;
          if (s1_arready_i) state_d = R;
        end else begin
          state_d = IDLE;
        end
      end
      R: begin
        if (sel_q == SEL_MEM) begin
          rvalid_o    = s0_rvalid_i;
          rdata_o     = s0_rdata_i;
          rresp_o     = s0_rresp_i;
          s0_rready_o = rready_i;
        end else if (sel_q == SEL_CLINT) begin
          rvalid_o    = s1_rvalid_i;
          rdata_o     = s1_rdata_i;
          s1_rready_o = rready_i;
        end
        if (rvalid_o && rready_i) state_d = IDLE;
      end
      ERR: begin
        rvalid_o = 1'b1;
        rresp_o  = 2'b11;
        if (rready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_xbar_rd.sv
// Directed self-checking bench for xbar_rd: routing, stalls, DECERR, reset and stray beats.
module tb_xbar_rd;

  logic        clock = 1'b0;
  logic        reset;
  logic        arvalid_i, arready_o;
  logic [31:0] araddr_i;
  logic        rvalid_o, rready_i;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        s0_arvalid_o, s0_arready_i, s0_rvalid_i, s0_rready_o;
  logic [31:0] s0_araddr_o, s0_rdata_i;
  logic [1:0]  s0_rresp_i;
  logic        s1_arvalid_o, s1_arready_i, s1_rvalid_i, s1_rready_o;
  logic [31:0] s1_araddr_o, s1_rdata_i;

  int checks = 0;
  int errors = 0;

  xbar_rd dut (
    .clock(clock), .reset(reset),
    .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
    .s0_arvalid_o(s0_arvalid_o), .s0_arready_i(s0_arready_i), .s0_araddr_o(s0_araddr_o),
    .s0_rvalid_i(s0_rvalid_i), .s0_rready_o(s0_rready_o), .s0_rdata_i(s0_rdata_i),
    .s0_rresp_i(s0_rresp_i),
    .s1_arvalid_o(s1_arvalid_o), .s1_arready_i(s1_arready_i), .s1_araddr_o(s1_araddr_o),
    .s1_rvalid_i(s1_rvalid_i), .s1_rready_o(s1_rready_o), .s1_rdata_i(s1_rdata_i)
  );

  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic applyStimulus();
    @(posedge clock);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    arvalid_i = 0; araddr_i = 0; rready_i = 0;
    s0_arready_i = 0; s0_rvalid_i = 0; s0_rdata_i = 0; s0_rresp_i = 0;
    s1_arready_i = 0; s1_rvalid_i = 0; s1_rdata_i = 0;
  endtask

  initial begin
    reset = 1;
    idleInputs();
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("rst_arready", 32'(arready_o), 0);
    checkOutput("rst_rvalid", 32'(rvalid_o), 0);
    checkOutput("rst_s0_arvalid", 32'(s0_arvalid_o), 0);
    checkOutput("rst_s0_araddr", s0_araddr_o, 0);
    reset = 0;
    #1;
    checkOutput("idle_arready", 32'(arready_o), 1);

    // CLINT read with immediate slave ready; stray s0 beat while slave 1 selected
    applyStimulus();
    arvalid_i = 1; araddr_i = 32'h0200_0000;
    #1 checkOutput("t1_arready", 32'(arready_o), 1);
    applyStimulus();
    arvalid_i = 0; s1_arready_i = 1; s0_rvalid_i = 1;
    #1;
    checkOutput("t1_s1_arvalid", 32'(s1_arvalid_o), 1);
    checkOutput("t1_s1_araddr", s1_araddr_o, 32'h0200_0000);
    checkOutput("t1_s0_arvalid", 32'(s0_arvalid_o), 0);
    checkOutput("t1_arready_busy", 32'(arready_o), 0);
    applyStimulus();
    s1_arready_i = 0; s1_rvalid_i = 1; s1_rdata_i = 32'h0000_1234; rready_i = 1;
    #1;
    checkOutput("t1_s1_arvalid_drop", 32'(s1_arvalid_o), 0);
    checkOutput("t1_rvalid", 32'(rvalid_o), 1);
    checkOutput("t1_rdata", rdata_o, 32'h0000_1234);
    checkOutput("t1_rresp", 32'(rresp_o), 0);
    checkOutput("t1_s1_rready", 32'(s1_rready_o), 1);
    checkOutput("t1_stray_s0_rready", 32'(s0_rready_o), 0);
    applyStimulus();
    idleInputs();
    #1;
    checkOutput("t1_back_idle", 32'(arready_o), 1);
    checkOutput("t1_rvalid_idle", 32'(rvalid_o), 0);

    // Back-to-back CLINT then memory
    applyStimulus();
    arvalid_i = 1; araddr_i = 32'h0200_000C;
    applyStimulus();
    arvalid_i = 0; s1_arready_i = 1;
    #1 checkOutput("t2a_s1_araddr", s1_araddr_o, 32'h0200_000C);
    applyStimulus();
    s1_arready_i = 0; s1_rvalid_i = 1; s1_rdata_i = 32'h0000_5678; rready_i = 1;
    arvalid_i = 1; araddr_i = 32'h8000_0010;
    #1;
    checkOutput("t2a_rdata", rdata_o, 32'h0000_5678);
    checkOutput("t2a_arready_in_r", 32'(arready_o), 0);
    applyStimulus();
    s1_rvalid_i = 0; rready_i = 0;
    #1 checkOutput("t2b_arready", 32'(arready_o), 1);
    applyStimulus();
    arvalid_i = 0; s0_arready_i = 1;
    #1;
    checkOutput("t2b_s0_arvalid", 32'(s0_arvalid_o), 1);
    checkOutput("t2b_s0_araddr", s0_araddr_o, 32'h8000_0010);
    checkOutput("t2b_s1_arvalid", 32'(s1_arvalid_o), 0);
    applyStimulus();
    s0_arready_i = 0; s0_rvalid_i = 1; s0_rdata_i = 32'hDEAD_BEEF; s0_rresp_i = 2'b00; rready_i = 1;
    #1;
    checkOutput("t2b_rdata", rdata_o, 32'hDEAD_BEEF);
    checkOutput("t2b_rresp", 32'(rresp_o), 0);
    checkOutput("t2b_s0_rready", 32'(s0_rready_o), 1);
    applyStimulus();
    idleInputs();

    // Unmapped address answered with DECERR, held until rready
    arvalid_i = 1; araddr_i = 32'h1000_0000;
    applyStimulus();
    arvalid_i = 0;
    #1;
    checkOutput("t3_rvalid", 32'(rvalid_o), 1);
    checkOutput("t3_rdata", rdata_o, 0);
    checkOutput("t3_rresp", 32'(rresp_o), 3);
    checkOutput("t3_s0_arvalid", 32'(s0_arvalid_o), 0);
    checkOutput("t3_s1_arvalid", 32'(s1_arvalid_o), 0);
    applyStimulus();
    #1 checkOutput("t3_rresp_held", 32'(rresp_o), 3);
    rready_i = 1;
    applyStimulus();
    rready_i = 0;
    #1;
    checkOutput("t3_rvalid_done", 32'(rvalid_o), 0);
    checkOutput("t3_arready_done", 32'(arready_o), 1);

    // Memory stalls AR for 5 cycles, then SLVERR with master stalling R for 3
    arvalid_i = 1; araddr_i = 32'h8000_0100;
    applyStimulus();
    arvalid_i = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("t4_s0_arvalid_%0d", i), 32'(s0_arvalid_o), 1);
      checkOutput($sformatf("t4_s0_araddr_%0d", i), s0_araddr_o, 32'h8000_0100);
      applyStimulus();
    end
    s0_arready_i = 1;
    applyStimulus();
    s0_arready_i = 0; s0_rvalid_i = 1; s0_rresp_i = 2'b10; s0_rdata_i = 32'hCAFE_0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("t4_rvalid_%0d", i), 32'(rvalid_o), 1);
      checkOutput($sformatf("t4_rresp_%0d", i), 32'(rresp_o), 2);
      checkOutput($sformatf("t4_rdata_%0d", i), rdata_o, 32'hCAFE_0001);
      checkOutput($sformatf("t4_s0_rready_%0d", i), 32'(s0_rready_o), 0);
      applyStimulus();
    end
    rready_i = 1;
    #1 checkOutput("t4_s0_rready", 32'(s0_rready_o), 1);
    applyStimulus();
    idleInputs();
    #1 checkOutput("t4_back_idle", 32'(arready_o), 1);

    // Reset during R with slave 1 selected
    arvalid_i = 1; araddr_i = 32'h0200_0004;
    applyStimulus();
    arvalid_i = 0; s1_arready_i = 1;
    applyStimulus();
    s1_arready_i = 0; s1_rvalid_i = 1; s1_rdata_i = 32'h0000_00AA;
    #1 checkOutput("t5_rvalid_pre", 32'(rvalid_o), 1);
    reset = 1;
    applyStimulus();
    #1;
    checkOutput("t5_arready", 32'(arready_o), 0);
    checkOutput("t5_rvalid", 32'(rvalid_o), 0);
    checkOutput("t5_rdata", rdata_o, 0);
    checkOutput("t5_s1_rready", 32'(s1_rready_o), 0);
    checkOutput("t5_s1_araddr", s1_araddr_o, 0);
    reset = 0;
    idleInputs();
    #1 checkOutput("t5_arready_rel", 32'(arready_o), 1);
    arvalid_i = 1; araddr_i = 32'h8000_0000;
    applyStimulus();
    arvalid_i = 0; s0_arready_i = 1;
    #1 checkOutput("t5_s0_araddr", s0_araddr_o, 32'h8000_0000);
    applyStimulus();
    s0_arready_i = 0; s0_rvalid_i = 1; s0_rdata_i = 32'h1111_2222; rready_i = 1;
    #1 checkOutput("t5_rdata_new", rdata_o, 32'h1111_2222);
    applyStimulus();
    idleInputs();

    // Stray slave 0 beat while idle
    s0_rvalid_i = 1; s0_rdata_i = 32'h5555_5555;
    #1;
    checkOutput("t6_rvalid", 32'(rvalid_o), 0);
    checkOutput("t6_s0_rready", 32'(s0_rready_o), 0);
    checkOutput("t6_arready", 32'(arready_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
